// File: rtl/dht_reader.sv
// dht_reader: single-wire DHT11/DHT22 reader (start pulse, response/bit timing,
// checksum and timeout reporting). Optional auto-poll: define DHT_AUTO_POLL_EN.
module dht_reader #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned SENSOR_TYPE   = 0,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned HOLDOFF_MS    = 1000,
  parameter int unsigned POLL_MS       = 2000
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         dht_data,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  output logic [1:0]  err,
  output logic [15:0] humidity,
  output logic [15:0] temperature
);

  localparam int unsigned US_DIV  = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int unsigned HOLD_US = HOLDOFF_MS * 1000;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE, S_HOLDOFF
  } state_t;

  state_t      state, state_next;
  logic        sync1, sync2, sync_prev, rise, fall;
  logic [31:0] div_cnt;
  logic        tick, tmo;
  logic [14:0] dur_us;
  logic [31:0] hold_us;
  logic [39:0] shreg;
  logic [5:0]  bit_idx;
  logic [7:0]  csum;
  logic [15:0] temp_dec;
  logic        waiting, shift_en, finish, load_data;
  logic [1:0]  finish_err;
  logic        poll_start, start_req;

  assign dht_data = (state == S_START_LOW) ? 1'b0 : 1'bz;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= dht_data;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fall = sync_prev & ~sync2;
  assign rise = ~sync_prev & sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 32'd1;
  end

  assign tick = (div_cnt == US_DIV - 1);
  assign tmo  = tick && (dur_us == 15'(TIMEOUT_US - 1));

`ifdef DHT_AUTO_POLL_EN
  localparam int unsigned POLL_US = POLL_MS * 1000;
  logic [31:0] poll_us;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    poll_us <= '0;
    else if (tick) poll_us <= poll_start ? '0 : poll_us + 32'd1;
  end

  assign poll_start = tick && (poll_us == POLL_US - 1);
`else
  assign poll_start = 1'b0 & (POLL_MS == 0);
`endif

  assign start_req = start | poll_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    dur_us <= '0;
    else if (state_next != state)  dur_us <= '0;
    else if (tick && dur_us != '1) dur_us <= dur_us + 15'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  hold_us <= '0;
    else if (state != S_HOLDOFF) hold_us <= '0;
    else if (tick)               hold_us <= hold_us + 32'd1;
  end

  assign csum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  always_comb begin
    temp_dec = shreg[23:8];
    if (SENSOR_TYPE == 1 && shreg[23])
      temp_dec = 16'd0 - {1'b0, shreg[22:8]};
  end

  always_comb begin
    state_next = state;
    waiting    = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    finish_err = ERR_OK;
    load_data  = 1'b0;
    unique case (state)
      S_IDLE:      if (start_req) state_next = S_START_LOW;
      S_START_LOW: if (tick && dur_us == 15'(START_LOW_US - 1)) state_next = S_RELEASE;
      S_RELEASE:   begin waiting = 1'b1; if (fall) state_next = S_RESP_LOW;  end
      S_RESP_LOW:  begin waiting = 1'b1; if (rise) state_next = S_RESP_HIGH; end
      S_RESP_HIGH: begin waiting = 1'b1; if (fall) state_next = S_BIT_LOW;   end
      S_BIT_LOW:   begin waiting = 1'b1; if (rise) state_next = S_BIT_HIGH;  end
      S_BIT_HIGH: begin
        waiting = 1'b1;
        if (fall) begin
          shift_en   = 1'b1;
          state_next = (bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
        end
      end
      S_CHECK: begin
        state_next = S_DONE;
        finish     = 1'b1;
        if (csum == shreg[7:0]) load_data  = 1'b1;
        else                    finish_err = ERR_CHECKSUM;
      end
      S_DONE:    state_next = S_HOLDOFF;
      S_HOLDOFF: if (tick && hold_us == HOLD_US - 1) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    // An edge seen in the same cycle as the timeout wins.
    if (waiting && state_next == state && tmo) begin
      state_next = S_DONE;
      finish     = 1'b1;
      finish_err = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bit_idx     <= '0;
      valid       <= 1'b0;
      err         <= ERR_OK;
      humidity    <= '0;
      temperature <= '0;
    end else begin
      valid <= finish;
      // Rise and fall share the same sync latency and dur_us clears on entry,
      // so it reads one less than the high time: >= here means high time > thresh.
      if (shift_en) begin
        shreg   <= {shreg[38:0], dur_us >= 15'(BIT_THRESH_US)};
        bit_idx <= bit_idx + 6'd1;
      end else if (state == S_START_LOW) begin
        bit_idx <= '0;
      end
      if (finish) err <= finish_err;
      if (load_data) begin
        humidity    <= shreg[39:24];
        temperature <= temp_dec;
      end
    end
  end

endmodule
